// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words, writes
// them into the instruction memory and holds the core in reset until a
// complete, word-aligned image has been loaded. All outputs are registered.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          we,
    output logic [31:0]   wa,
    output logic [31:0]   wd,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FINISH = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    // State and datapath registers
    state_t          state_reg, state_next;
    logic [1:0]      byte_idx_reg, byte_idx_next;
    logic [23:0]     asm_reg, asm_next;
    logic [CW-1:0]   word_count_reg, word_count_next;

    // Registered outputs and their next values
    logic            we_reg, we_next;
    logic [31:0]     wa_reg, wa_next;
    logic [31:0]     wd_reg, wd_next;
    logic            in_ready_reg, in_ready_next;
    logic            cpu_reset_reg, cpu_reset_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    // Handshake and decode helpers
    logic            accept;
    logic            full;
    logic            load_entry;
    logic [2:0]      lane_hit;

    // in_ready_reg is high exactly while in LOAD, so it doubles as the
    // state qualifier for the handshake.
    assign accept = in_valid && in_ready_reg;
    assign full   = (word_count_reg == DEPTH_W);

    // A new load may only begin from a quiescent state.
    assign load_entry = start &&
                        ((state_reg == S_IDLE) ||
                         (state_reg == S_DONE) ||
                         (state_reg == S_ERROR));

    // Byte lanes 0..2 of the assembly register; lane 3 never needs storage
    // because the fourth byte goes straight into the write word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_hit[gi] = accept && (state_reg == S_LOAD) && !full &&
                                  !in_last && (byte_idx_reg == 2'(gi));
            assign asm_next[8*gi +: 8] = load_entry   ? 8'h00 :
                                         lane_hit[gi] ? in_data :
                                                        asm_reg[8*gi +: 8];
        end
    endgenerate

    // State register: every state bit and registered output, async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            byte_idx_reg   <= 2'd0;
            asm_reg        <= 24'h0;
            word_count_reg <= '0;
            we_reg         <= 1'b0;
            wa_reg         <= 32'h0;
            wd_reg         <= 32'h0;
            in_ready_reg   <= 1'b0;
            cpu_reset_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            asm_reg        <= asm_next;
            word_count_reg <= word_count_next;
            we_reg         <= we_next;
            wa_reg         <= wa_next;
            wd_reg         <= wd_next;
            in_ready_reg   <= in_ready_next;
            cpu_reset_reg  <= cpu_reset_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    // Next-state logic: transitions plus byte index, word count and write data
    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        word_count_next = word_count_reg;
        we_next         = 1'b0;
        wa_next         = wa_reg;
        wd_next         = wd_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next      = S_LOAD;
                    byte_idx_next   = 2'd0;
                    word_count_next = '0;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    if (full) begin
                        // Image longer than the memory: abort, nothing written.
                        state_next = S_ERROR;
                    end else if (byte_idx_reg == 2'd3) begin
                        // Word complete: write it at the pre-increment count.
                        we_next         = 1'b1;
                        wd_next         = {in_data, asm_reg};
                        wa_next         = 32'(word_count_reg) << 2;
                        word_count_next = word_count_reg + CW'(1);
                        byte_idx_next   = 2'd0;
                        if (in_last) begin
                            state_next = S_FINISH;
                        end
                    end else if (in_last) begin
                        // Image ends mid-word: the partial word is dropped.
                        state_next = S_ERROR;
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end
            end

            S_FINISH: begin
                // One cycle for the final write strobe to retire.
                state_next = S_DONE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: status flags follow the state being entered so that
    // they are valid in the same cycle as that state.
    always_comb begin
        in_ready_next  = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        cpu_reset_next = 1'b1;

        case (state_next)
            S_LOAD: begin
                in_ready_next = 1'b1;
                busy_next     = 1'b1;
            end
            S_FINISH: begin
                busy_next = 1'b1;
            end
            S_DONE: begin
                done_next      = 1'b1;
                cpu_reset_next = 1'b0;
            end
            S_ERROR: begin
                err_next = 1'b1;
            end
            default: begin
                in_ready_next = 1'b0;
            end
        endcase
    end

    assign in_ready   = in_ready_reg;
    assign we         = we_reg;
    assign wa         = wa_reg;
    assign wd         = wd_reg;
    assign cpu_reset  = cpu_reset_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios plus randomized images, with every
// DUT output compared each cycle against a queue-based behavioural model.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_FINISH = 2;
    localparam int P_DONE   = 3;
    localparam int P_ERROR  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          we;
    logic [31:0]   wa;
    logic [31:0]   wd;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] word_count;

    int n_vec  = 0;
    int n_miss = 0;
    bit gap_start = 1'b0;

    logic [63:0] wr_q[$];

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .we(we), .wa(wa), .wd(wd),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // The load is described by the list of bytes accepted so far; a write
    // is due whenever that list reaches a multiple of four.
    int          m_phase = P_IDLE;
    logic [7:0]  m_bytes[$];
    int          m_wc = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_wa = 32'h0;
    logic [31:0] m_wd = 32'h0;
    int          m_n;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_IDLE;
            m_bytes.delete();
            m_wc = 0;
            m_we = 1'b0;
            m_wa = 32'h0;
            m_wd = 32'h0;
        end else begin
            m_we = 1'b0;
            case (m_phase)
                P_LOAD: begin
                    if (in_valid) begin
                        if (m_wc == DEPTH) begin
                            m_phase = P_ERROR;
                        end else begin
                            m_bytes.push_back(in_data);
                            m_n = m_bytes.size();
                            if (m_n % 4 == 0) begin
                                m_we = 1'b1;
                                m_wd = {m_bytes[m_n-1], m_bytes[m_n-2], m_bytes[m_n-3], m_bytes[m_n-4]};
                                m_wa = 32'(4 * (m_n / 4 - 1));
                                m_wc = m_n / 4;
                                if (in_last) m_phase = P_FINISH;
                            end else if (in_last) begin
                                m_phase = P_ERROR;
                            end
                        end
                    end
                end
                P_FINISH: m_phase = P_DONE;
                default: begin
                    if (start) begin
                        m_phase = P_LOAD;
                        m_bytes.delete();
                        m_wc = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("in_ready",   in_ready,   m_phase == P_LOAD);
        chk("busy",       busy,       (m_phase == P_LOAD) || (m_phase == P_FINISH));
        chk("done",       done,       m_phase == P_DONE);
        chk("err",        err,        m_phase == P_ERROR);
        chk("cpu_reset",  cpu_reset,  m_phase != P_DONE);
        chk("we",         we,         m_we);
        chk("wa",         wa,         m_wa);
        chk("wd",         wd,         m_wd);
        chk("word_count", word_count, 32'(m_wc));
    end

    // Log every memory write seen on the port
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_q.push_back({wa, wd});
            $display("write wa=0x%08h wd=0x%08h", wa, wd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input int gap_pct);
        int  tries;
        bit  sent;
        tries = 0;
        sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            start = 1'b0;
            if (tries > 60) begin
                n_vec++;
                n_miss++;
                $display("FAIL send_timeout: byte 0x%02h not accepted, in_ready=%0b, required 1", d, in_ready);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            tries++;
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'($urandom);
                if (gap_start && ($urandom_range(7) == 0)) start = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data  = d;
                in_last  = last;
                if (in_ready === 1'b1) sent = 1'b1;
            end
        end
    endtask

    task automatic send_image(input logic [7:0] img[$], input int last_pos, input int gap_pct);
        foreach (img[i]) send(img[i], i == last_pos, gap_pct);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] img1[$];
        logic [7:0] img[$];
        int         len;

        img1 = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_cpu_reset",  cpu_reset,  1);
        chk("rst_word_count", word_count, 0);
        reset = 1'b0;

        // 1: normal two-word load, in_valid held high
        $display("test 1: normal load");
        wr_q.delete();
        pulse_start();
        send_image(img1, 7, 0);
        idle(2);
        chk("t1_done",       done,       1);
        chk("t1_cpu_reset",  cpu_reset,  0);
        chk("t1_word_count", word_count, 2);
        chk("t1_nwrites",    wr_q.size(), 2);
        chk("t1_wa0", wr_q[0][63:32], 32'h0);
        chk("t1_wd0", wr_q[0][31:0],  32'h00500513);
        chk("t1_wa1", wr_q[1][63:32], 32'h4);
        chk("t1_wd1", wr_q[1][31:0],  32'h00600593);

        // 2: same image with random gaps
        $display("test 2: gaps");
        wr_q.delete();
        pulse_start();
        send_image(img1, 7, 50);
        idle(2);
        chk("t2_done",    done,        1);
        chk("t2_nwrites", wr_q.size(), 2);
        chk("t2_wd0", wr_q[0][31:0], 32'h00500513);
        chk("t2_wd1", wr_q[1][31:0], 32'h00600593);

        // 3: six-byte image ends mid-word
        $display("test 3: bad length");
        wr_q.delete();
        pulse_start();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_image(img, 5, 0);
        idle(1);
        chk("t3_err",       err,       1);
        chk("t3_cpu_reset", cpu_reset, 1);
        idle(3);
        chk("t3_nwrites", wr_q.size(), 1);
        chk("t3_wa0",     wr_q[0][63:32], 32'h0);
        chk("t3_wd0",     wr_q[0][31:0],  32'h44332211);

        // 4: overflow with DEPTH words already written
        $display("test 4: overflow");
        wr_q.delete();
        pulse_start();
        img.delete();
        for (int i = 0; i < 17; i++) img.push_back(8'(i + 1));
        send_image(img, -1, 0);
        idle(1);
        chk("t4_err",        err,        1);
        chk("t4_word_count", word_count, 4);
        idle(2);
        chk("t4_nwrites", wr_q.size(), 4);
        chk("t4_wa3",     wr_q[3][63:32], 32'hC);
        chk("t4_wd3",     wr_q[3][31:0],  32'h100F0E0D);

        // 5: asynchronous reset in the middle of a word
        $display("test 5: reset mid-load");
        pulse_start();
        img = '{8'hAA, 8'hBB, 8'hCC};
        send_image(img, -1, 0);
        idle(1);
        #2 reset = 1'b1;
        #1;
        chk("t5_in_ready",   in_ready,   0);
        chk("t5_busy",       busy,       0);
        chk("t5_cpu_reset",  cpu_reset,  1);
        chk("t5_word_count", word_count, 0);
        chk("t5_wa",         wa,         0);
        chk("t5_wd",         wd,         0);
        @(negedge clk);
        reset = 1'b0;
        wr_q.delete();
        pulse_start();
        img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_image(img, 3, 0);
        idle(2);
        chk("t5_nwrites", wr_q.size(), 1);
        chk("t5_wa0",     wr_q[0][63:32], 32'h0);
        chk("t5_wd0",     wr_q[0][31:0],  32'hD4C3B2A1);

        // 6: start ignored while loading, honoured from DONE
        $display("test 6: reload");
        pulse_start();
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        pulse_start();
        send(8'h03, 1'b0, 0);
        send(8'h04, 1'b1, 0);
        idle(2);
        chk("t6_done",       done,       1);
        chk("t6_word_count", word_count, 1);
        pulse_start();
        idle(1);
        chk("t6_cpu_reset",  cpu_reset,  1);
        chk("t6_done0",      done,       0);
        chk("t6_word_count0", word_count, 0);
        chk("t6_busy",       busy,       1);
        send(8'h05, 1'b1, 0);
        idle(2);

        // Randomized images: random length, gaps and stray start pulses
        $display("random images");
        gap_start = 1'b1;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(1, 17);
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            pulse_start();
            send_image(img, len - 1, $urandom_range(0, 60));
            idle($urandom_range(1, 3));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
